// File: rtl/clk_step_pkg.sv
// -----------------------------------------------------------------------------
// clk_step_pkg
//
// Shared definitions for the clock/reset conditioning stage (clk_step_ctrl)
// and its input debouncer (btn_debounce).
//
// Contents:
//   state_t            - controller state encoding
//   *_DEFAULT          - default values for DIV, DEB_CYCLES and RST_EDGES
//   IDX_*              - bit positions of the three conditioned inputs
//   cnt_width()        - width of a counter that must hold 0..n-1 (min 1 bit)
// -----------------------------------------------------------------------------
package clk_step_pkg;

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_RUN   = 3'd1,
        S_IDLE  = 3'd2,
        S_PULSE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam int DIV_DEFAULT        = 4;
    localparam int DEB_CYCLES_DEFAULT = 8;
    localparam int RST_EDGES_DEFAULT  = 2;

    // Positions of the conditioned inputs in the debouncer vectors.
    localparam int IDX_MODE = 0;
    localparam int IDX_STEP = 1;
    localparam int IDX_RST  = 2;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Conditions one raw front-panel input: two-flop synchroniser followed by a
// stability counter. The accepted level only changes after DEB_CYCLES
// consecutive synchronised samples that differ from the current level.
// A one-cycle pulse marks each accepted 0->1 transition.
//
// Parameters:
//   DEB_CYCLES  consecutive stable samples needed to accept a level (>=1)
//
// Ports:
//   clk    in   clock, rising edge
//   srst   in   synchronous active-high reset (clears everything to 0)
//   raw    in   asynchronous raw input
//   level  out  debounced level
//   rise   out  1-cycle pulse, registered together with the level change
// -----------------------------------------------------------------------------
module btn_debounce
    import clk_step_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic srst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                 CNT_W    = cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             level_reg;
    logic             level_next;
    logic             rise_reg;
    logic             rise_next;

    // The counter tracks how many samples in a row have disagreed with the
    // accepted level; any agreeing sample restarts the run.
    always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        if (sync2_reg != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
        rise_next = level_next & ~level_reg;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/clk_step_ctrl.sv
// -----------------------------------------------------------------------------
// clk_step_ctrl
//
// Clock-and-reset conditioning stage in front of the control unit. Produces a
// divided, gateable CPU clock (CLOCK_AUTO), a latched halt flag (HLT_IN) and a
// stretched system reset (BTN_RESET) from the board clock and raw panel inputs.
//
// Build option:
//   CLKCTRL_STEP_EN  defined   -> run/single-step switch and step button active
//                    undefined -> run mode only; SW_MODE and BTN_STEP_RAW unused
//
// Parameters:
//   DIV         board cycles per CLOCK_AUTO half-period (>=1)
//   DEB_CYCLES  stable samples to accept a panel input level (>=1)
//   RST_EDGES   minimum CLOCK_AUTO falling edges while BTN_RESET is high (>=1)
//
// Ports:
//   CLOCK          in   board clock, rising edge
//   RESET          in   synchronous active-high power-on reset
//   SW_MODE        in   raw switch, 0 = run, 1 = single-step
//   BTN_STEP_RAW   in   raw step button, active-high
//   BTN_RESET_RAW  in   raw reset button, active-high
//   HLT            in   microcode halt bit from the control unit
//   CLOCK_AUTO     out  CPU clock, registered
//   HLT_IN         out  halted flag, registered
//   BTN_RESET      out  system reset, registered
// -----------------------------------------------------------------------------
module clk_step_ctrl
    import clk_step_pkg::*;
#(
    parameter int DIV        = DIV_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int RST_EDGES  = RST_EDGES_DEFAULT
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic SW_MODE,
    input  logic BTN_STEP_RAW,
    input  logic BTN_RESET_RAW,
    input  logic HLT,
    output logic CLOCK_AUTO,
    output logic HLT_IN,
    output logic BTN_RESET
);

    localparam int                  DIV_W       = cnt_width(DIV);
    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(DIV - 1);
    localparam int                  FALL_W      = cnt_width(RST_EDGES + 1);
    localparam logic [FALL_W-1:0]   FALL_TARGET = FALL_W'(RST_EDGES);

    // ------------------------------------------------------------------
    // Input conditioning: one debouncer per panel input
    // ------------------------------------------------------------------
    logic [2:0] raw_vec;
    logic [2:0] level_vec;
    logic [2:0] rise_vec;

    assign raw_vec[IDX_MODE] = SW_MODE;
    assign raw_vec[IDX_STEP] = BTN_STEP_RAW;
    assign raw_vec[IDX_RST]  = BTN_RESET_RAW;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            btn_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk   (CLOCK),
                .srst  (RESET),
                .raw   (raw_vec[gi]),
                .level (level_vec[gi]),
                .rise  (rise_vec[gi])
            );
        end
    endgenerate

    logic mode_level;
    logic step_rise;
    logic rst_level;
    logic rst_rise;

    assign mode_level = level_vec[IDX_MODE];
    assign step_rise  = rise_vec[IDX_STEP];
    assign rst_level  = level_vec[IDX_RST];
    assign rst_rise   = rise_vec[IDX_RST];

    // Conditioned signals with no consumer in this build.
    logic unused_deb;
`ifdef CLKCTRL_STEP_EN
    assign unused_deb = ^{rise_vec[IDX_MODE], level_vec[IDX_STEP]};
`else
    assign unused_deb = ^{rise_vec[IDX_MODE], level_vec[IDX_STEP], mode_level, step_rise};
`endif

    // ------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------
    state_t              state_reg;
    state_t              state_next;
    logic [DIV_W-1:0]    div_reg;
    logic [DIV_W-1:0]    div_next;
    logic [FALL_W-1:0]   fall_cnt_reg;
    logic [FALL_W-1:0]   fall_cnt_next;
    logic                clk_auto_reg;
    logic                clk_auto_next;
    logic                hlt_in_reg;
    logic                hlt_in_next;
    logic                btn_reset_reg;
    logic                btn_reset_next;
    logic                tick;
    logic                rst_done;

    assign tick     = (div_reg == DIV_LAST);
    assign rst_done = (fall_cnt_reg >= FALL_TARGET) && !rst_level;

    always_comb begin
        state_next    = state_reg;
        clk_auto_next = clk_auto_reg;
        fall_cnt_next = fall_cnt_reg;

        case (state_reg)
            S_RST: begin
                // Leaving is checked before toggling so that BTN_RESET never
                // drops on the same edge as a CLOCK_AUTO transition.
                if (rst_done) begin
`ifdef CLKCTRL_STEP_EN
                    state_next = mode_level ? S_IDLE : S_RUN;
`else
                    state_next = S_RUN;
`endif
                end else if (tick) begin
                    clk_auto_next = ~clk_auto_reg;
                    if (clk_auto_reg && (fall_cnt_reg != FALL_TARGET)) begin
                        fall_cnt_next = fall_cnt_reg + FALL_W'(1);
                    end
                end
            end

            S_RUN: begin
                if (tick) begin
                    if (clk_auto_reg) begin
                        // A high phase always completes, whatever the switch
                        // did meanwhile; decisions happen only before a rise.
                        clk_auto_next = 1'b0;
                    end else if (HLT) begin
                        state_next = S_HALT;
`ifdef CLKCTRL_STEP_EN
                    end else if (mode_level) begin
                        state_next = S_IDLE;
`endif
                    end else begin
                        clk_auto_next = 1'b1;
                    end
                end
            end

`ifdef CLKCTRL_STEP_EN
            S_IDLE: begin
                if (clk_auto_reg) begin
                    // Only reachable straight out of S_RST after a long reset
                    // hold; finish that high phase before accepting steps.
                    if (tick) begin
                        clk_auto_next = 1'b0;
                    end
                end else if (step_rise) begin
                    if (HLT) begin
                        state_next = S_HALT;
                    end else begin
                        state_next    = S_PULSE;
                        clk_auto_next = 1'b1;
                    end
                end else if (!mode_level) begin
                    state_next = S_RUN;
                end
            end

            S_PULSE: begin
                if (tick) begin
                    clk_auto_next = 1'b0;
                    state_next    = S_IDLE;
                end
            end
`endif

            S_HALT: begin
                clk_auto_next = 1'b0;
            end

            default: begin
                state_next = S_RST;
            end
        endcase

        // A reset press wins from any state, including S_RST itself, and
        // restarts the edge count. The clock level is preserved so the
        // current phase finishes at the next tick instead of being cut short.
        if (rst_rise) begin
            state_next    = S_RST;
            clk_auto_next = clk_auto_reg;
            fall_cnt_next = '0;
        end

        // Divider restarts on every state entry so each state sees full
        // half-periods from its first cycle.
        if ((state_next != state_reg) || rst_rise || tick) begin
            div_next = '0;
        end else begin
            div_next = div_reg + DIV_W'(1);
        end

        hlt_in_next    = (state_next == S_HALT);
        btn_reset_next = (state_next == S_RST);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_reg     <= S_RST;
            div_reg       <= '0;
            fall_cnt_reg  <= '0;
            clk_auto_reg  <= 1'b0;
            hlt_in_reg    <= 1'b0;
            btn_reset_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            fall_cnt_reg  <= fall_cnt_next;
            clk_auto_reg  <= clk_auto_next;
            hlt_in_reg    <= hlt_in_next;
            btn_reset_reg <= btn_reset_next;
        end
    end

    assign CLOCK_AUTO = clk_auto_reg;
    assign HLT_IN     = hlt_in_reg;
    assign BTN_RESET  = btn_reset_reg;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_step_ctrl
//
// Bench for clk_step_ctrl with DIV=4, DEB_CYCLES=8, RST_EDGES=2. Whenever
// stimulus is applied, the output transitions it must cause (signal, new
// level, board-cycle number) are queued; a monitor watching CLOCK_AUTO,
// HLT_IN and BTN_RESET pops and compares one entry per observed transition.
// Any transition with nothing queued is an error, and the queue must be empty
// at the end. Step-mode scenarios are included when CLKCTRL_STEP_EN is defined.
// -----------------------------------------------------------------------------
module tb_clk_step_ctrl;

    localparam int SIG_CA = 1;
    localparam int SIG_HI = 2;
    localparam int SIG_BR = 3;

    logic CLOCK = 1'b0;
    logic RESET;
    logic SW_MODE;
    logic BTN_STEP_RAW;
    logic BTN_RESET_RAW;
    logic HLT;
    logic CLOCK_AUTO;
    logic HLT_IN;
    logic BTN_RESET;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic        mon_en  = 1'b0;
    logic        prev_ca = 1'b0;
    logic        prev_hi = 1'b0;
    logic        prev_br = 1'b0;
    logic [31:0] exp_q[$];

    clk_step_ctrl #(
        .DIV        (4),
        .DEB_CYCLES (8),
        .RST_EDGES  (2)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .SW_MODE       (SW_MODE),
        .BTN_STEP_RAW  (BTN_STEP_RAW),
        .BTN_RESET_RAW (BTN_RESET_RAW),
        .HLT           (HLT),
        .CLOCK_AUTO    (CLOCK_AUTO),
        .HLT_IN        (HLT_IN),
        .BTN_RESET     (BTN_RESET)
    );

    always #5 CLOCK = ~CLOCK;

    // Board-cycle counter: number of rising edges seen so far.
    initial begin
        forever begin
            @(posedge CLOCK);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h (sig/val/cycle)", tag, got, exp);
        end
    endtask

    // Event word: [31:28] signal id, [24] new level, [23:0] cycle number.
    function automatic logic [31:0] ev(input int sig, input logic val, input int c);
        logic [3:0]  s;
        logic [23:0] cc;
        s  = sig[3:0];
        cc = c[23:0];
        return {s, 3'b000, val, cc};
    endfunction

    task automatic expect_ev(input int sig, input logic val, input int c);
        exp_q.push_back(ev(sig, val, c));
    endtask

    task automatic take_event(input int sig, input logic val, input string tag);
        logic [31:0] want;
        want = 32'h0;
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
        end
        $display("event %s -> %0b at cycle %0d", tag, val, cyc);
        check(tag, ev(sig, val, cyc), want);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge CLOCK);
    endtask

    // Monitor: outputs are sampled on the falling board-clock edge.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (mon_en) begin
                if (CLOCK_AUTO !== prev_ca) begin
                    take_event(SIG_CA, CLOCK_AUTO, "ev_clock_auto");
                    prev_ca = CLOCK_AUTO;
                end
                if (HLT_IN !== prev_hi) begin
                    take_event(SIG_HI, HLT_IN, "ev_hlt_in");
                    prev_hi = HLT_IN;
                end
                if (BTN_RESET !== prev_br) begin
                    take_event(SIG_BR, BTN_RESET, "ev_btn_reset");
                    prev_br = BTN_RESET;
                end
            end
        end
    end

    initial begin
        int r0;
        int c;
`ifdef CLKCTRL_STEP_EN
        int p;
        int q;
        int s;
        int u;
`endif
        RESET         = 1'b1;
        SW_MODE       = 1'b0;
        BTN_STEP_RAW  = 1'b0;
        BTN_RESET_RAW = 1'b0;
        HLT           = 1'b0;

        // ---- power-on reset, 3 cycles ----
        repeat (3) @(negedge CLOCK);
        check("rst_clock_auto", {31'd0, CLOCK_AUTO}, 32'd0);
        check("rst_hlt_in",     {31'd0, HLT_IN},     32'd0);
        check("rst_btn_reset",  {31'd0, BTN_RESET},  32'd1);
        RESET = 1'b0;
        r0 = cyc;

        // Reset stretch: toggles every 4 cycles, release after 2nd fall,
        // then run mode with period 8 from a freshly cleared divider.
        expect_ev(SIG_CA, 1'b1, r0 + 4);
        expect_ev(SIG_CA, 1'b0, r0 + 8);
        expect_ev(SIG_CA, 1'b1, r0 + 12);
        expect_ev(SIG_CA, 1'b0, r0 + 16);
        expect_ev(SIG_BR, 1'b0, r0 + 17);
        expect_ev(SIG_CA, 1'b1, r0 + 21);
        expect_ev(SIG_CA, 1'b0, r0 + 25);
        prev_ca = 1'b0;
        prev_hi = 1'b0;
        prev_br = 1'b1;
        mon_en  = 1'b1;

        // ---- halt while CLOCK_AUTO is low ----
        wait_until(r0 + 26);
        HLT = 1'b1;
        expect_ev(SIG_HI, 1'b1, r0 + 29);
        wait_until(r0 + 29 + 200);
        check("halt_hlt_in_held",    {31'd0, HLT_IN},     32'd1);
        check("halt_clock_auto_low", {31'd0, CLOCK_AUTO}, 32'd0);

        // ---- reset press out of halt (12-cycle press) ----
        c = cyc;
        BTN_RESET_RAW = 1'b1;
        HLT           = 1'b0;
        expect_ev(SIG_HI, 1'b0, c + 11);
        expect_ev(SIG_BR, 1'b1, c + 11);
        expect_ev(SIG_CA, 1'b1, c + 15);
        expect_ev(SIG_CA, 1'b0, c + 19);
        expect_ev(SIG_CA, 1'b1, c + 23);
        expect_ev(SIG_CA, 1'b0, c + 27);
        expect_ev(SIG_BR, 1'b0, c + 28);
        expect_ev(SIG_CA, 1'b1, c + 32);
        expect_ev(SIG_CA, 1'b0, c + 36);
        wait_until(c + 12);
        BTN_RESET_RAW = 1'b0;

`ifdef CLKCTRL_STEP_EN
        // ---- mode switch: debounced level lands during the c+32..c+36
        //      high phase; that phase completes, then no further rise ----
        wait_until(c + 23);
        SW_MODE = 1'b1;
        wait_until(c + 60);
        check("idle_clock_auto_low", {31'd0, CLOCK_AUTO}, 32'd0);

        // ---- short 3-cycle step glitches: no activity ----
        for (int k = 0; k < 3; k++) begin
            BTN_STEP_RAW = 1'b1;
            repeat (3) @(negedge CLOCK);
            BTN_STEP_RAW = 1'b0;
            repeat (5) @(negedge CLOCK);
        end

        // ---- clean 12-cycle press: one 4-cycle pulse, 11 cycles later ----
        p = cyc;
        BTN_STEP_RAW = 1'b1;
        expect_ev(SIG_CA, 1'b1, p + 11);
        expect_ev(SIG_CA, 1'b0, p + 15);
        wait_until(p + 12);
        BTN_STEP_RAW = 1'b0;
        wait_until(p + 30);

        // ---- held step: one pulse, release, second press: second pulse ----
        q = cyc;
        BTN_STEP_RAW = 1'b1;
        expect_ev(SIG_CA, 1'b1, q + 11);
        expect_ev(SIG_CA, 1'b0, q + 15);
        wait_until(q + 100);
        BTN_STEP_RAW = 1'b0;
        wait_until(q + 120);
        BTN_STEP_RAW = 1'b1;
        expect_ev(SIG_CA, 1'b1, q + 131);
        expect_ev(SIG_CA, 1'b0, q + 135);
        wait_until(q + 132);
        BTN_STEP_RAW = 1'b0;
        wait_until(q + 150);

        // ---- reset press landing in S_PULSE ----
        s = cyc;
        BTN_STEP_RAW = 1'b1;
        expect_ev(SIG_CA, 1'b1, s + 11);
        expect_ev(SIG_BR, 1'b1, s + 13);
        expect_ev(SIG_CA, 1'b0, s + 17);
        expect_ev(SIG_CA, 1'b1, s + 21);
        expect_ev(SIG_CA, 1'b0, s + 25);
        expect_ev(SIG_BR, 1'b0, s + 26);
        wait_until(s + 2);
        BTN_RESET_RAW = 1'b1;
        wait_until(s + 12);
        BTN_STEP_RAW = 1'b0;
        wait_until(s + 14);
        BTN_RESET_RAW = 1'b0;
        wait_until(s + 40);
        check("pulse_rst_btn_reset", {31'd0, BTN_RESET}, 32'd0);

        // ---- back to run mode from S_IDLE ----
        u = cyc;
        SW_MODE = 1'b0;
        expect_ev(SIG_CA, 1'b1, u + 15);
        expect_ev(SIG_CA, 1'b0, u + 19);
        wait_until(u + 21);
`else
        wait_until(c + 38);
`endif
        mon_en = 1'b0;
        check("pending_events", exp_q.size(), 32'd0);
        check("end_hlt_in",     {31'd0, HLT_IN},    32'd0);
        check("end_btn_reset",  {31'd0, BTN_RESET}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
